// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART TX byte channel between NUM_REQ requester streams.
// A requester is granted for a whole packet (closed by req_last), grants
// rotate round-robin, an optional {4'hA, id} header byte precedes every
// packet, and a granted requester that goes quiet mid-packet loses the
// grant after TIMEOUT cycles.
//
// Handshake rule (all streams, both directions): a byte moves on every
// clock edge where valid && ready are both high. A source holds valid and
// data steady until that happens. Here req_ready is combinational and
// never depends on tx_ready while tx_valid is low; tx_valid/tx_data are
// registered and tx_data is frozen while tx_valid && !tx_ready.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int HEADER_EN = 1,
    parameter int TIMEOUT   = 1024,
    parameter int TO_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [3:0]           grant_id,
    output logic                 timeout_pulse,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_VAL    = TO_W'(TIMEOUT);
    localparam logic [3:0]      LAST_INIT = 4'(NUM_REQ - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_grant_id;
    logic [3:0]        r_last_grant;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;

    // Requester buses widened to the 16-requester maximum so a 4-bit
    // grant index always selects in range.
    logic [15:0]       w_valid_x;
    logic [15:0]       w_last_x;
    logic [127:0]      w_data_x;
    logic [15:0]       w_ready_x;

    logic              w_any_req;
    logic [3:0]        w_pick;
    logic              w_gnt_valid;
    logic              w_gnt_last;
    logic [7:0]        w_gnt_data;
    logic              w_load_ok;
    logic              w_timeout;
    logic              w_hdr_load;
    logic              w_accept;

    assign w_valid_x   = 16'(req_valid);
    assign w_last_x    = 16'(req_last);
    assign w_data_x    = 128'(req_data);

    assign w_any_req   = |req_valid;
    assign w_gnt_valid = w_valid_x[r_grant_id];
    assign w_gnt_last  = w_last_x[r_grant_id];
    assign w_gnt_data  = w_data_x[{r_grant_id, 3'b000} +: 8];

    // The output register can take a new byte when empty or draining now.
    assign w_load_ok   = !r_tx_valid || tx_ready;

    // Timeout fires once the idle count has reached TIMEOUT while in DATA.
    assign w_timeout   = (TIMEOUT != 0) && (r_state == ST_DATA) &&
                         (r_to_cnt == TO_VAL);

    // Round-robin pick: first requesting index after last_grant, wrapping.
    // Walking the offsets from far to near lets the nearest one win.
    always_comb begin
        int         v_idx;
        logic [3:0] v_idx4;
        v_idx  = 0;
        v_idx4 = 4'd0;
        w_pick = 4'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx  = (int'(r_last_grant) + k) % NUM_REQ;
            v_idx4 = v_idx[3:0];
            if (w_valid_x[v_idx4]) begin
                w_pick = v_idx4;
            end
        end
    end

    // Next-state logic plus the per-state ready/load strobes.
    always_comb begin
        w_next_state = r_state;
        w_ready_x    = 16'd0;
        w_hdr_load   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                if (w_load_ok) begin
                    w_hdr_load   = 1'b1;
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_timeout) begin
                    // Revoke the grant; no byte is taken in this cycle.
                    w_next_state = ST_IDLE;
                end else begin
                    w_ready_x[r_grant_id] = w_load_ok;
                    w_accept              = w_gnt_valid && w_load_ok;
                    if (w_accept && w_gnt_last) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant capture in IDLE and round-robin pointer update at packet end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_id   <= 4'd0;
            r_last_grant <= LAST_INIT;
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant_id <= w_pick;
            end
            if ((w_accept && w_gnt_last) || w_timeout) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    // Idle counter: counts DATA cycles with the granted valid low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_DATA || w_accept) begin
            r_to_cnt <= '0;
        end else if (TIMEOUT != 0 && !w_gnt_valid && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Output byte register toward the UART serializer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else if (w_hdr_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= {4'hA, r_grant_id};
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_gnt_data;
        end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign req_ready     = w_ready_x[NUM_REQ-1:0];
    assign tx_valid      = r_tx_valid;
    assign tx_data       = r_tx_data;
    assign busy          = (r_state != ST_IDLE);
    assign grant_id      = r_grant_id;
    assign timeout_pulse = w_timeout;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one instance with headers and TIMEOUT=8, and
// one header-less instance, both with two requesters.
module tb_uart_tx_arbiter;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT with header, TIMEOUT=8 ----------------
    logic        v0, v1, l0, l1;
    logic [7:0]  d0, d1;
    logic        tx_ready;
    wire  [1:0]  req_valid = {v1, v0};
    wire  [1:0]  req_last  = {l1, l0};
    wire  [15:0] req_data  = {d1, d0};
    wire  [1:0]  req_ready;
    wire         tx_valid;
    wire  [7:0]  tx_data;
    wire         busy;
    wire  [3:0]  grant_id;
    wire         timeout_pulse;
    wire  [1:0]  dbg_state;

    uart_tx_arbiter #(
        .NUM_REQ(2), .HEADER_EN(1), .TIMEOUT(8), .TO_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse),
        .o_dbg_state(dbg_state)
    );

    // ---------------- DUT without header ----------------
    logic        nv0, nv1, nl0, nl1;
    logic [7:0]  nd0, nd1;
    logic        n_tx_ready;
    wire  [1:0]  n_req_ready;
    wire         n_tx_valid;
    wire  [7:0]  n_tx_data;
    wire         n_busy;
    wire  [3:0]  n_grant_id;
    wire         n_timeout_pulse;
    wire  [1:0]  n_dbg_state;

    uart_tx_arbiter #(
        .NUM_REQ(2), .HEADER_EN(0), .TIMEOUT(0), .TO_W(16)
    ) dut_nh (
        .clk(clk), .rst(rst),
        .req_valid({nv1, nv0}), .req_data({nd1, nd0}), .req_last({nl1, nl0}),
        .req_ready(n_req_ready),
        .tx_valid(n_tx_valid), .tx_data(n_tx_data), .tx_ready(n_tx_ready),
        .busy(n_busy), .grant_id(n_grant_id), .timeout_pulse(n_timeout_pulse),
        .o_dbg_state(n_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic        hold_chk = 1'b0;
    logic        stalled  = 1'b0;
    logic [7:0]  held     = 8'd0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte monitor plus stall-stability watch, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
            if (hold_chk && !rst) begin
                if (stalled) begin
                    check_eq("hold_valid", 32'(tx_valid), 32'd1);
                    check_eq("hold_data", 32'(tx_data), 32'(held));
                end
                check_eq("ready_vs_load", 32'(req_ready[1] & tx_valid & ~tx_ready), 32'd0);
                stalled = tx_valid && !tx_ready;
                held    = tx_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic compare_stream(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check_eq(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input int src, input logic [7:0] d, input logic l);
        int   n;
        logic rdy;
        if (src == 0) begin v0 = 1'b1; d0 = d; l0 = l; end
        else          begin v1 = 1'b1; d1 = d; l1 = l; end
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (src == 0) ? req_ready[0] : req_ready[1];
            if (rdy) break;
            n++;
            if (n > 200) begin
                check_eq("drv_budget", 32'(n), 32'd200);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int src, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
            drive_byte(src, b, i == n - 1);
        end
        if (src == 0) begin v0 = 1'b0; l0 = 1'b0; end
        else          begin v1 = 1'b0; l1 = 1'b0; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [3:0] pat;
        int         lat;
        int         n;
        pat = 4'b1001;
        v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0; tx_ready = 1'b1;
        nv0 = 0; nv1 = 0; nl0 = 0; nl1 = 0; nd0 = 0; nd1 = 0; n_tx_ready = 1'b1;
        rst = 1'b1;
        #1;

        // Reset values
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_timeout", 32'(timeout_pulse), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: single packet from requester 0
        exp_q = '{8'hA0, 8'h11, 8'h22};
        send_pkt(0, 8'h11, 8'h22, 8'h00, 2);
        compare_stream("t1_stream");
        check_eq("t1_busy", 32'(busy), 32'd0);
        check_eq("t1_grant", 32'(grant_id), 32'd0);

        // T2: both requesters streaming, grants alternate starting at 0
        do_reset();
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h81, 8'h82,
                  8'hA0, 8'h03, 8'h04, 8'hA1, 8'h83, 8'h84};
        fork
            begin
                send_pkt(0, 8'h01, 8'h02, 8'h00, 2);
                send_pkt(0, 8'h03, 8'h04, 8'h00, 2);
            end
            begin
                send_pkt(1, 8'h81, 8'h82, 8'h00, 2);
                send_pkt(1, 8'h83, 8'h84, 8'h00, 2);
            end
        join
        compare_stream("t2_stream");
        check_eq("t2_grant", 32'(grant_id), 32'd1);

        // T3: requester 1 while tx_ready toggles 1,0,0,1
        exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33};
        hold_chk = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    tx_ready = pat[i % 4];
                    @(posedge clk);
                    #1;
                end
                tx_ready = 1'b1;
            end
            send_pkt(1, 8'h31, 8'h32, 8'h33, 3);
        join
        compare_stream("t3_stream");
        hold_chk = 1'b0;

        // T4: requester 0 goes quiet mid-packet; requester 1 waits
        exp_q = '{8'hA0, 8'h55, 8'hA1, 8'h66};
        fork
            begin
                drive_byte(0, 8'h55, 1'b0);
                v0 = 1'b0;
                lat = 0;
                for (int i = 1; i <= 20; i++) begin
                    @(negedge clk);
                    if (timeout_pulse) begin
                        lat = i;
                        break;
                    end
                end
                check_eq("t4_to_latency", 32'(lat), 32'd9);
                @(negedge clk);
                check_eq("t4_pulse_width", 32'(timeout_pulse), 32'd0);
                check_eq("t4_state_idle", 32'(dbg_state), 32'd0);
            end
            send_pkt(1, 8'h66, 8'h00, 8'h00, 1);
        join
        compare_stream("t4_stream");
        check_eq("t4_grant", 32'(grant_id), 32'd1);

        // T5: reset while a byte sits stalled in the output register
        tx_ready = 1'b0;
        v0 = 1'b1; d0 = 8'h77; l0 = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_loaded", 32'(tx_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("t5_tx_data", 32'(tx_data), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_req_ready", 32'(req_ready), 32'd0);
        check_eq("t5_grant", 32'(grant_id), 32'd0);
        v0 = 1'b0;
        got_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        exp_q = '{8'hA0, 8'h12, 8'h13};
        send_pkt(0, 8'h12, 8'h13, 8'h00, 2);
        compare_stream("t5_stream");

        // T6: no header, single byte from requester 1
        nv1 = 1'b1; nd1 = 8'h7E; nl1 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_arb_txv", 32'(n_tx_valid), 32'd0);
        check_eq("t6_arb_busy", 32'(n_busy), 32'd1);
        check_eq("t6_ready1", 32'(n_req_ready), 32'd2);
        @(posedge clk);
        #1;
        nv1 = 1'b0; nl1 = 1'b0;
        check_eq("t6_txv", 32'(n_tx_valid), 32'd1);
        check_eq("t6_txd", 32'(n_tx_data), 32'h7E);
        check_eq("t6_busy_end", 32'(n_busy), 32'd0);
        check_eq("t6_grant", 32'(n_grant_id), 32'd1);
        @(posedge clk);
        #1;
        check_eq("t6_drained", 32'(n_tx_valid), 32'd0);

        // T6b: both request, requester 0 wins after requester 1 finished
        nv0 = 1'b1; nd0 = 8'h3C; nl0 = 1'b1;
        nv1 = 1'b1; nd1 = 8'hC3; nl1 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6b_grant0", 32'(n_grant_id), 32'd0);
        @(posedge clk);
        #1;
        nv0 = 1'b0; nl0 = 1'b0;
        check_eq("t6b_data0", 32'(n_tx_data), 32'h3C);
        @(posedge clk);
        #1;
        check_eq("t6b_grant1", 32'(n_grant_id), 32'd1);
        @(posedge clk);
        #1;
        nv1 = 1'b0; nl1 = 1'b0;
        check_eq("t6b_data1", 32'(n_tx_data), 32'hC3);
        check_eq("t6b_timeout", 32'(n_timeout_pulse), 32'd0);
        check_eq("t6b_state", 32'(n_dbg_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
